// File: rtl/alu_issue.sv
// Issue stage for a 4-entry register file: LDI retires in one cycle, ALU ops go IDLE->EXEC->WB
// with operands captured at transfer; done/illegal/zero/retired are registered status outputs.
module alu_issue (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs1,
    input  logic [1:0] instr_rs2,
    input  logic [7:0] instr_imm,
    output logic [7:0] alu_op,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    input  logic [7:0] alu_result,
    input  logic [1:0] rd_sel,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       illegal,
    output logic       zero,
    output logic [7:0] retired
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [7:0] OP_LDI = 8'h20;

    state_t     state_q, state_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];
    logic [7:0] alu_op_q, alu_op_d;
    logic [7:0] alu_in1_q, alu_in1_d;
    logic [7:0] alu_in2_q, alu_in2_d;
    logic [1:0] rd_q, rd_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;
    logic       zero_q, zero_d;
    logic [7:0] retired_q, retired_d;
    logic       xfer;
    logic       op_is_alu;

    always_comb begin
        op_is_alu = 1'b0;
        case (instr_op)
            8'h01, 8'h02, 8'h0E, 8'h0F, 8'h10, 8'h11: op_is_alu = 1'b1;
            default:                                  op_is_alu = 1'b0;
        endcase
    end

    // Ready is masked by rst so nothing transfers while reset is held.
    assign instr_ready = (state_q == IDLE) && !rst;
    assign xfer        = instr_valid && instr_ready;

    always_comb begin
        state_d   = state_q;
        for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
        alu_op_d  = 8'h00;
        alu_in1_d = 8'h00;
        alu_in2_d = 8'h00;
        rd_d      = rd_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        zero_d    = zero_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (op_is_alu) begin
                        // Operands are read before any write lands, so rd==rs sees the old value.
                        alu_op_d  = instr_op;
                        alu_in1_d = regs_q[instr_rs1];
                        alu_in2_d = regs_q[instr_rs2];
                        rd_d      = instr_rd;
                        state_d   = EXEC;
                    end else if (instr_op == OP_LDI) begin
                        regs_d[instr_rd] = instr_imm;
                        done_d           = 1'b1;
                        zero_d           = (instr_imm == 8'h00);
                        retired_d        = retired_q + 8'd1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                regs_d[rd_q] = alu_result;
                done_d       = 1'b1;
                zero_d       = (alu_result == 8'h00);
                retired_d    = retired_q + 8'd1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
            alu_op_q  <= 8'h00;
            alu_in1_q <= 8'h00;
            alu_in2_q <= 8'h00;
            rd_q      <= 2'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b0;
            retired_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
            alu_op_q  <= alu_op_d;
            alu_in1_q <= alu_in1_d;
            alu_in2_q <= alu_in2_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            zero_q    <= zero_d;
            retired_q <= retired_d;
        end
    end

    assign alu_op  = alu_op_q;
    assign alu_in1 = alu_in1_q;
    assign alu_in2 = alu_in2_q;
    assign rd_data = regs_q[rd_sel];
    assign done    = done_q;
    assign illegal = illegal_q;
    assign zero    = zero_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed table, random instructions against a register-file model,
// reset-in-writeback and back-to-back LDI wrap sequences.
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2;
    logic [7:0] instr_imm;
    logic [7:0] alu_op, alu_in1, alu_in2;
    logic [7:0] alu_result;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic       done, illegal, zero;
    logic [7:0] retired;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_r [4];
    int         m_ret;
    bit         m_zero;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm(instr_imm),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
        .rd_sel(rd_sel), .rd_data(rd_data),
        .done(done), .illegal(illegal), .zero(zero), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [7:0] ref_alu(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            8'h01:   return a + b;
            8'h02:   return a - b;
            8'h0E:   return ~a;
            8'h0F:   return a & b;
            8'h10:   return a | b;
            8'h11:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit is_alu_op(input logic [7:0] op);
        return (op == 8'h01) || (op == 8'h02) || (op == 8'h0E) ||
               (op == 8'h0F) || (op == 8'h10) || (op == 8'h11);
    endfunction

    // Downstream ALU: result registered one clock after the opcode is presented.
    always @(posedge clk) alu_result <= ref_alu(alu_op, alu_in1, alu_in2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_sel = i[1:0];
            #1;
            chk({tag, "_reg"}, rd_data, m_r[i]);
        end
        chk({tag, "_retired"}, retired, m_ret & 8'hFF);
        chk({tag, "_zero"}, zero, m_zero);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_ret  = 0;
        m_zero = 0;
    endtask

    task automatic run_instr(input logic [7:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [7:0] imm);
        logic [7:0] a, b, res;
        bit alu, ldi, got_done, got_ill;
        int lat;
        a   = m_r[rs1];
        b   = m_r[rs2];
        alu = is_alu_op(op);
        ldi = (op == 8'h20);
        @(negedge clk);
        chk("idle_ready", instr_ready, 1);
        chk("pulse_single", {done, illegal}, 2'b00);
        chk("idle_alu_op", alu_op, 8'h00);
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op = 8'($urandom); instr_imm = 8'($urandom);
        lat = 0; got_done = 0; got_ill = 0;
        while (!got_done && !got_ill && lat < 8) begin
            @(negedge clk);
            lat++;
            if (alu && lat == 1) begin
                chk("exec_alu_op", alu_op, op);
                chk("exec_in1", alu_in1, a);
                chk("exec_in2", alu_in2, b);
                chk("exec_ready", instr_ready, 0);
            end
            if (alu && lat == 2) begin
                chk("wb_alu_op", {alu_op, alu_in1, alu_in2}, 24'h0);
                chk("wb_ready", instr_ready, 0);
            end
            if (done && illegal) chk("done_illegal_excl", {done, illegal}, 2'b10);
            got_done = done;
            got_ill  = illegal;
        end
        if (alu) begin
            res = ref_alu(op, a, b);
            m_r[rd] = res; m_ret++; m_zero = (res == 8'h00);
        end else if (ldi) begin
            m_r[rd] = imm; m_ret++; m_zero = (imm == 8'h00);
        end
        chk("latency", lat, alu ? 3 : 1);
        chk("pulse_kind", {got_done, got_ill}, (alu || ldi) ? 2'b10 : 2'b01);
        chk("post_alu_op", alu_op, 8'h00);
        chk_state("post");
    endtask

    typedef struct {
        logic [7:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [7:0] imm;
        logic [7:0] exp_val;
        logic       exp_zero;
        logic [7:0] exp_ret;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{8'h20, 2'd1, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 8'd1};
        vecs[1] = '{8'h20, 2'd2, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0, 8'd2};
        vecs[2] = '{8'h01, 2'd3, 2'd1, 2'd2, 8'h00, 8'h08, 1'b0, 8'd3};
        vecs[3] = '{8'h20, 2'd0, 2'd0, 2'd0, 8'h0F, 8'h0F, 1'b0, 8'd4};
        vecs[4] = '{8'h20, 2'd1, 2'd0, 2'd0, 8'h0F, 8'h0F, 1'b0, 8'd5};
        vecs[5] = '{8'h02, 2'd2, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1, 8'd6};
        vecs[6] = '{8'h33, 2'd0, 2'd1, 2'd2, 8'h00, 8'h0F, 1'b1, 8'd6};
        vecs[7] = '{8'h20, 2'd1, 2'd0, 2'd0, 8'hA5, 8'hA5, 1'b0, 8'd7};
        vecs[8] = '{8'h11, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1, 8'd8};

        rst = 1'b1; instr_valid = 1'b0; instr_op = 8'h00; instr_rd = 2'd0;
        instr_rs1 = 2'd0; instr_rs2 = 2'd0; instr_imm = 8'h00; rd_sel = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", instr_ready, 0);
        chk("rst_alu", {alu_op, alu_in1, alu_in2}, 24'h0);
        chk("rst_pulses", {done, illegal}, 2'b00);
        chk_state("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", instr_ready, 1);

        for (int i = 0; i < 9; i++) begin
            run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            rd_sel = vecs[i].rd;
            #1;
            chk("vec_val", rd_data, vecs[i].exp_val);
            chk("vec_zero", zero, vecs[i].exp_zero);
            chk("vec_ret", retired, vecs[i].exp_ret);
        end

        for (int i = 0; i < 150; i++) begin
            logic [7:0] op;
            case ($urandom_range(0, 7))
                0: op = 8'h01;
                1: op = 8'h02;
                2: op = 8'h0E;
                3: op = 8'h0F;
                4: op = 8'h10;
                5: op = 8'h11;
                6: op = 8'h20;
                default: op = 8'($urandom);
            endcase
            run_instr(op, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
        end

        // Reset in WB of an ADD into R3 must drop the write-back and the done pulse.
        run_instr(8'h20, 2'd3, 2'd0, 2'd0, 8'h77);
        run_instr(8'h20, 2'd1, 2'd0, 2'd0, 8'h11);
        run_instr(8'h20, 2'd2, 2'd0, 2'd0, 8'h22);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 8'h01; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("rwb_exec_op", alu_op, 8'h01);
        @(negedge clk);
        chk("rwb_in_wb", instr_ready, 0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rwb_ready_low", instr_ready, 0);
        chk_state("rwb_during");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rwb_rel_ready", instr_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rwb_no_done", done, 0);
        end
        chk_state("rwb_after");

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i > 0) chk("b2b_done", done, 1);
            chk("b2b_ready", instr_ready, 1);
            chk("b2b_retired", retired, i & 8'hFF);
            instr_valid = 1'b1; instr_op = 8'h20;
            instr_rd = 2'($urandom); instr_imm = 8'($urandom);
            m_r[instr_rd] = instr_imm; m_ret++; m_zero = (instr_imm == 8'h00);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_last_done", done, 1);
        chk("b2b_wrap", retired, 8'h00);
        chk_state("b2b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  block accepts an instruction this cycle.
REQ-006 instr_op  input  8  opcode.
REQ-007 instr_rd, instr_rs1, instr_rs2  input  2 each  destination and source register indices.
REQ-008 instr_imm  input  8  immediate for LDI.
REQ-009 alu_op  output  8  opcode to downstream ALU.
REQ-010 alu_in1, alu_in2  output  8 each  operands to ALU.
REQ-011 alu_result  input  8  ALU registered result, valid one clk after alu_op is presented.
REQ-012 rd_sel  input  2  debug read-port index.
REQ-013 rd_data  output  8  contents of register rd_sel, combinational.
REQ-014 done  output  1  one-cycle pulse when an instruction retires.
REQ-015 illegal  output  1  one-cycle pulse when an unsupported opcode is dropped.
REQ-016 zero  output  1  set when the last retired write value was 0x00.
REQ-017 retired  output  8  count of retired instructions.

Function
REQ-018 The block SHALL hold a register file R0..R3, 8 bits each.
REQ-019 ALU opcodes: 0x01 ADD, 0x02 SUB, 0x0E CPL, 0x0F AND, 0x10 OR, 0x11 XOR; local opcode 0x20 LDI; all others illegal.
REQ-020 FSM states SHALL be IDLE, EXEC, WB.
REQ-021 instr_ready SHALL be 1 only in IDLE; transfer occurs when instr_valid and instr_ready are both 1 at a rising edge.
REQ-022 IDLE, transfer, ALU opcode: latch op, rd, R[rs1], R[rs2]; go to EXEC.
REQ-023 IDLE, transfer, LDI: write instr_imm to R[rd], pulse done next cycle, update zero, increment retired; stay IDLE.
REQ-024 IDLE, transfer, illegal opcode: no register change, pulse illegal next cycle, retired unchanged; stay IDLE.
REQ-025 EXEC (one cycle): alu_op = latched op, alu_in1/alu_in2 = latched operands; go to WB.
REQ-026 WB (one cycle): write alu_result to R[rd] at the closing edge, pulse done in the following cycle, update zero, increment retired; return to IDLE.
REQ-027 Outside EXEC, alu_op SHALL be 0x00 and alu_in1/alu_in2 SHALL be 0x00.
REQ-028 Operands SHALL be captured at transfer; rd == rs1/rs2 uses pre-write values.
REQ-029 ALU instruction latency SHALL be 3 cycles from transfer edge to done pulse; throughput one ALU instruction per 3 cycles, one LDI per cycle.
REQ-030 retired SHALL wrap 0xFF -> 0x00.
REQ-031 rd_data SHALL reflect a write in the cycle after the write edge.
REQ-032 done and illegal SHALL never be high together.

Reset
REQ-033 rst high SHALL immediately force FSM to IDLE, R0..R3 = 0x00, alu_op/alu_in1/alu_in2 = 0x00, done = 0, illegal = 0, zero = 0, retired = 0x00.
REQ-034 instr_ready SHALL be 0 while rst is high and 1 in the first cycle after release.
REQ-035 rst asserted in EXEC or WB SHALL abort the instruction with no write-back and no done pulse.

Verification
REQ-036 LDI R1=0x05, LDI R2=0x03, ADD R3=R1+R2 -> R3 = 0x08, done 3 times, retired = 3, zero = 0.
REQ-037 LDI R0=0x0F, LDI R1=0x0F, SUB R2=R0-R1 -> R2 = 0x00, zero = 1; ADD done exactly 3 cycles after transfer, instr_ready low during EXEC/WB.
REQ-038 instr_op = 0x33 offered -> illegal pulses once, registers and retired unchanged, alu_op stays 0x00.
REQ-039 XOR R1=R1^R1 with R1 = 0xA5 -> alu_in1 = alu_in2 = 0xA5 in EXEC, R1 = 0x00 after WB.
REQ-040 rst pulsed during WB of ADD targeting R3 (pre-value 0x77) -> R3 = 0x00, no done, retired = 0x00.
REQ-041 256 back-to-back LDIs -> retired wraps to 0x00, done high every cycle after the first transfer.
